pi_round_engine: RTL and testbench

Buffered, multi-round bit-plane permuter for the matrix encoder datapath. It accepts 25-bit slices, each holding a 5x5 bit matrix, through a valid/ready handshake and queues them in a parametrised FIFO. For each slice it applies the centred pi permutation, forward or inverse, a per-slice number of times at one round per cycle. The result is presented on a valid/ready output port. It is the sequential successor of the single-shot combinational slice swapper and sits between the file-driven slice source and the output writer.

---
 rtl/pi_pkg.sv | 9 +
 rtl/pi_map.sv | 19 +
 rtl/pi_round_engine.sv | 76 +++++++
 tb/tb_pi_round_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// pi_pkg: shared constants, FSM states and the mod-5 helper for the pi round engine.
package pi_pkg;
   localparam int SIDE  = 5;
   localparam int CELLS = 25;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
   function automatic int mod5(input int v);
      return v % SIDE;
   endfunction
endpackage

// File: rtl/pi_map.sv
// pi_map: one combinational round of the centred pi permutation, forward or inverse.
module pi_map
   import pi_pkg::*;
#(
   parameter int OFFSET = 3
) (
   input  logic [CELLS-1:0] din,
   input  logic             inv,
   output logic [CELLS-1:0] dout
);
   for (genvar i = 0; i < CELLS; i++) begin : g_cell
      localparam int XC = mod5(i % SIDE + OFFSET);
      localparam int YC = mod5(i / SIDE + OFFSET);
      // Gather form: the source of cell i is where the opposite map sends i.
      localparam int FD = SIDE * mod5(2 * XC + 3 * YC + SIDE - OFFSET) + mod5(YC + SIDE - OFFSET);
      localparam int ID = SIDE * mod5(XC + SIDE - OFFSET) + mod5(XC + 3 * YC + SIDE - OFFSET);
      assign dout[i] = inv ? din[FD] : din[ID];
   end
endmodule

// File: rtl/pi_round_engine.sv
// pi_round_engine: FIFO-buffered multi-round pi permuter with valid/ready ports.
module pi_round_engine
   import pi_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 5,
   parameter int OFFSET = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CELLS-1:0]         in_data,
   input  logic [CNT_W-1:0]         in_rounds,
   input  logic                     in_inv,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CELLS-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = 1 + CNT_W + CELLS;
   logic [EW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   state_t           state, state_nx;
   logic [CELLS-1:0] work, mapped;
   logic [CNT_W-1:0] cnt;
   logic             inv, push, pop, done;
   assign in_ready  = level != LW'(DEPTH);
   assign push      = in_valid && in_ready;
   assign pop       = state == IDLE && level != '0;
   assign done      = state == RUN && cnt == '0;
   assign out_valid = state == HOLD;
   assign busy      = state != IDLE;
   pi_map #(.OFFSET(OFFSET)) u_map (.din(work), .inv(inv), .dout(mapped));
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {in_inv, in_rounds, in_data};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = pop ? RUN : IDLE;
         RUN:     state_nx = cnt == '0 ? HOLD : RUN;
         HOLD:    state_nx = out_ready ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         work     <= '0;
         cnt      <= '0;
         inv      <= 1'b0;
         out_data <= '0;
      end else begin
         if (pop) {inv, cnt, work} <= mem[rd_ptr];
         else if (state == RUN && cnt != '0) begin
            work <= mapped;
            cnt  <= cnt - CNT_W'(1);
         end
         if (done) out_data <= work;
      end
endmodule

// File: tb/tb_pi_round_engine.sv
// tb_pi_round_engine: scoreboard bench for the pi round engine.
module tb_pi_round_engine;
   localparam int DEPTH = 8;
   localparam int CW    = 5;
   localparam int OFF   = 3;
   logic          clk = 1'b0, rst = 1'b0;
   logic          in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
   logic [24:0]   in_data = '0;
   logic [CW-1:0] in_rounds = '0;
   logic          in_ready, out_valid, busy;
   logic [24:0]   out_data;
   logic [3:0]    level;
   logic [24:0]   sb[$];
   int            checks = 0, failures = 0, cyc = 0, k_acc = 0, n_out = 0;
   pi_round_engine #(.DEPTH(DEPTH), .CNT_W(CW), .OFFSET(OFF)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_rounds(in_rounds), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .level(level), .busy(busy));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [24:0] model(input logic [24:0] d, input int r, input bit inv);
      logic [24:0] cur, nxt;
      int x, y, nx, ny;
      cur = d;
      for (int k = 0; k < r; k++) begin
         nxt = '0;
         for (int i = 0; i < 25; i++) begin
            x = (i % 5 + OFF) % 5;
            y = (i / 5 + OFF) % 5;
            if (!inv) begin nx = y; ny = (2 * x + 3 * y) % 5; end
            else begin nx = (x + 3 * y) % 5; ny = x; end
            nx = (nx + 5 - OFF) % 5;
            ny = (ny + 5 - OFF) % 5;
            nxt[5 * ny + nx] = cur[i];
         end
         cur = nxt;
      end
      return cur;
   endfunction
   task automatic send(input logic [24:0] d, input int r, input bit inv, input logic [24:0] exp);
      int n;
      bit acc;
      in_valid = 1'b1; in_data = d; in_rounds = r[CW-1:0]; in_inv = inv;
      n = 0;
      do begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1; n++;
      end while (!acc && n < 200);
      checks++;
      if (acc) begin sb.push_back(exp); k_acc = cyc; end
      else begin failures++; $display("FAIL send_accept in_ready=%b required=1", in_ready); end
      in_valid = 1'b0;
   endtask
   task automatic wait_idle;
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((sb.size() != 0 || busy || level != 0 || out_valid) && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 2000) begin
         checks++; failures++;
         $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      end
   endtask
   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      checks += 4;
      if (out_data !== 25'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
      if (level !== 4'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rel_out_valid got=%b exp=0", out_valid); end
   endtask
   task automatic test_vectors;
      logic [24:0] x, y;
      wait_idle;
      send(25'h0000001, 1, 0, 25'h0000400);
      send(25'h0001000, 1, 0, 25'h0001000);
      send(25'h0000400, 1, 1, 25'h0000001);
      x = 25'h1A5F0C3;
      y = model(x, 7, 0);
      send(x, 7, 0, y);
      send(y, 7, 1, x);
      wait_idle;
   endtask
   task automatic test_rounds24;
      logic [24:0] d;
      wait_idle;
      for (int i = 0; i < 4; i++) begin
         d = 25'($urandom);
         send(d, 24, i % 2, d);
      end
      wait_idle;
   endtask
   task automatic test_latency(input int r);
      logic [24:0] d;
      int k, n;
      wait_idle;
      d = 25'($urandom);
      send(d, r, 0, model(d, r, 0));
      k = k_acc; n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (cyc != k + r + 2) begin
         failures++;
         $display("FAIL latency_r%0d got_edge=%0d exp_edge=%0d", r, cyc - k, r + 2);
      end
      wait_idle;
   endtask
   task automatic test_backpressure;
      logic [24:0] d[DEPTH+2];
      int idx, n, n0;
      bit acc;
      wait_idle;
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) d[i] = 25'($urandom);
      idx = 0; n = 0;
      in_valid = 1'b1; in_data = d[0]; in_rounds = 5'd3; in_inv = 1'b0;
      for (int p = 0; p < 2; p++) begin
         if (p == 1) begin
            checks += 3;
            if (idx != DEPTH + 1) begin failures++; $display("FAIL bp_accepts got=%0d exp=%0d", idx, DEPTH + 1); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
            if (level !== 4'(DEPTH)) begin failures++; $display("FAIL bp_level got=%0d exp=%0d", level, DEPTH); end
            n0 = n_out; out_ready = 1'b1; n = 0;
         end
         while ((p == 0 ? n < 3 * DEPTH : idx < DEPTH + 2) && n < 200) begin
            @(negedge clk); acc = in_ready && idx < DEPTH + 2;
            @(posedge clk); #1; n++;
            if (acc) begin sb.push_back(model(d[idx], 3, idx[0])); idx++; end
            if (idx < DEPTH + 2) begin in_data = d[idx]; in_inv = idx[0]; end
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      wait_idle;
      checks++;
      if (n_out - n0 != DEPTH + 2) begin failures++; $display("FAIL bp_out_count got=%0d exp=%0d", n_out - n0, DEPTH + 2); end
   endtask
   task automatic test_push_pop;
      logic [24:0] d;
      int n;
      wait_idle;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin d = 25'($urandom); send(d, 2, 1, model(d, 2, 1)); end
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (level !== 4'd3) begin failures++; $display("FAIL pp_level_before got=%0d exp=3", level); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      d = 25'($urandom);
      in_valid = 1'b1; in_data = d; in_rounds = 5'd2; in_inv = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(model(d, 2, 1));
      checks += 2;
      if (level !== 4'd3) begin failures++; $display("FAIL pp_level_after got=%0d exp=3", level); end
      if (busy !== 1'b1) begin failures++; $display("FAIL pp_busy got=%b exp=1", busy); end
      for (int i = 0; i < 6; i++) begin
         in_inv = ~in_inv; in_data = 25'($urandom);
         @(posedge clk); #1;
      end
      wait_idle;
   endtask
   task automatic test_reset_mid;
      logic [24:0] d;
      int n;
      wait_idle;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin d = 25'($urandom); send(d, 20, 0, model(d, 20, 0)); end
      checks += 2;
      if (level !== 4'd3) begin failures++; $display("FAIL rm_level_pre got=%0d exp=3", level); end
      if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_pre got=%b exp=1", busy); end
      #2 rst = 1'b0;
      #1;
      sb.delete();
      checks += 2;
      if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      checks += 2;
      if (level !== 4'd0) begin failures++; $display("FAIL rm_level got=%0d exp=0", level); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
      out_ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      out_ready = 1'b0;
      d = 25'($urandom);
      send(d, 0, 0, d);
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (out_data !== d) begin failures++; $display("FAIL rh_hold_data got=%h exp=%h", out_data, d); end
      #2 rst = 1'b0;
      #1;
      sb.delete();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rh_out_valid got=%b exp=0", out_valid); end
      @(negedge clk) rst = 1'b1;
      out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
   endtask
   initial begin
      fork
         forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
               n_out++; checks++;
               if (sb.size() == 0) begin
                  failures++; $display("FAIL unexpected_output got=%h exp=none", out_data);
               end else if (out_data !== sb[0]) begin
                  failures++; $display("FAIL out_data got=%h exp=%h", out_data, sb[0]);
                  void'(sb.pop_front());
               end else void'(sb.pop_front());
            end
         end
      join_none
      test_reset;
      test_vectors;
      test_latency(0);
      test_latency(1);
      test_latency(5);
      test_rounds24;
      test_backpressure;
      test_push_pop;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
